// File: rtl/matrix_loader.sv
// Input stage for the matrix multiplier: deserializes one element stream into
// row-major operand matrices A then B and holds the pair until acknowledged.
module matrix_loader #(
  parameter int N  = 3,
  parameter int DW = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     in_data,
  input  logic              in_last,
  output logic [N*N*DW-1:0] a_flat,
  output logic [N*N*DW-1:0] b_flat,
  output logic              mat_valid,
  input  logic              mat_ack,
  output logic              load_err
);

  localparam int NE = N * N;
  localparam int IW = (NE > 1) ? $clog2(NE) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NE - 1);

  typedef enum logic [1:0] {
    LOAD_A,
    LOAD_B,
    HOLD
  } state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [NE*DW-1:0]   a_q, a_d;
  logic [NE*DW-1:0]   b_q, b_d;
  logic               mat_valid_q, mat_valid_d;
  logic               load_err_q, load_err_d;
  logic               accept;
  logic               at_last;

  // Ready is a pure state decode so upstream never sees a path from in_valid.
  assign in_ready = (state_q != HOLD);
  assign accept   = in_valid & in_ready;
  assign at_last  = (idx_q == LAST_IDX);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    a_d        = a_q;
    b_d        = b_q;
    load_err_d = 1'b0;

    case (state_q)
      LOAD_A: begin
        if (accept) begin
          a_d[idx_q*DW +: DW] = in_data;
          if (in_last) begin
            load_err_d = 1'b1;
            idx_d      = '0;
          end else if (at_last) begin
            state_d = LOAD_B;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      LOAD_B: begin
        if (accept) begin
          b_d[idx_q*DW +: DW] = in_data;
          if (at_last && in_last) begin
            state_d = HOLD;
            idx_d   = '0;
          end else if (at_last || in_last) begin
            // Framing error: the element is kept but the whole set is dropped.
            load_err_d = 1'b1;
            state_d    = LOAD_A;
            idx_d      = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      HOLD: begin
        if (mat_ack) begin
          state_d = LOAD_A;
          idx_d   = '0;
        end
      end

      default: begin
        state_d = LOAD_A;
        idx_d   = '0;
      end
    endcase

    mat_valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LOAD_A;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      mat_valid_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      mat_valid_q <= mat_valid_d;
      load_err_q  <= load_err_d;
    end
  end

  assign a_flat    = a_q;
  assign b_flat    = b_q;
  assign mat_valid = mat_valid_q;
  assign load_err  = load_err_q;

endmodule
